fir_mac_sched: RTL and testbench

FIR_MAC_SCHED -- requirements
Module: fir_mac_sched

---
 rtl/fir_mac_sched.sv | 131 +++++++++++++
 tb/tb_fir_mac_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_sched.sv
// rtl/fir_mac_sched.sv - 3-tap FIR, one shared multiplier, one tap per cycle
// Optional output clipping to [-64,63] with out_sat: define FIR_MAC_SAT_EN.
module fir_mac_sched (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic signed [2:0] in_data,
  output logic              in_ready,
  input  logic              cfg_we,
  input  logic        [1:0] cfg_addr,
  input  logic signed [5:0] cfg_data,
  output logic              cfg_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [6:0] out_data,
  output logic              out_sat
);

  typedef enum logic [2:0] {IDLE, MAC0, MAC1, MAC2, OUT} state_t;

  state_t state, state_nxt;

  logic signed [2:0]  x0, x1, x2;
  logic signed [5:0]  c0, c1, c2;
  logic signed [10:0] acc;
  logic signed [2:0]  mul_x;
  logic signed [5:0]  mul_c;
  logic signed [8:0]  prod;
  logic signed [10:0] acc_sum;
  logic        [6:0]  res_data;
  logic               res_sat;
  logic               accept;
  logic               cfg_ok;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign cfg_ok   = (state == IDLE) && (cfg_addr != 2'd3);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC0;
      MAC0:    state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The MAC state selects which tap feeds the shared multiplier.
  always_comb begin
    mul_x = '0;
    mul_c = '0;
    case (state)
      MAC0:    begin mul_x = x0; mul_c = c0; end
      MAC1:    begin mul_x = x1; mul_c = c1; end
      MAC2:    begin mul_x = x2; mul_c = c2; end
      default: begin mul_x = '0; mul_c = '0; end
    endcase
  end

  assign prod    = $signed({{6{mul_x[2]}}, mul_x}) * $signed({{3{mul_c[5]}}, mul_c});
  assign acc_sum = acc + $signed({{2{prod[8]}}, prod});

`ifdef FIR_MAC_SAT_EN
  always_comb begin
    res_data = acc_sum[6:0];
    res_sat  = 1'b0;
    if (acc_sum > 11'sd63) begin
      res_data = 7'h3F;
      res_sat  = 1'b1;
    end else if (acc_sum < -11'sd64) begin
      res_data = 7'h40;
      res_sat  = 1'b1;
    end
  end
`else
  always_comb begin
    res_data = acc_sum[6:0];
    res_sat  = 1'b0;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      x0        <= '0;
      x1        <= '0;
      x2        <= '0;
      acc       <= '0;
      c0        <= 6'sd8;
      c1        <= 6'sd5;
      c2        <= 6'sd10;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= 1'b0;
      // A write landing on the accepting edge is seen by that sample's MAC0.
      if (cfg_we) begin
        if (cfg_ok) begin
          case (cfg_addr)
            2'd0:    c0 <= cfg_data;
            2'd1:    c1 <= cfg_data;
            default: c2 <= cfg_data;
          endcase
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (accept) begin
        x2  <= x1;
        x1  <= x0;
        x0  <= in_data;
        acc <= '0;
      end
      if (state == MAC0 || state == MAC1 || state == MAC2) acc <= acc_sum;
      if (state == MAC2) begin
        out_valid <= 1'b1;
        out_data  <= $signed(res_data);
        out_sat   <= res_sat;
      end else if (state == OUT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// tb/tb_fir_mac_sched.sv - randomized bench for fir_mac_sched with a sum-of-products reference
module tb_fir_mac_sched;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              in_valid;
  logic signed [2:0] in_data;
  logic              in_ready;
  logic              cfg_we;
  logic        [1:0] cfg_addr;
  logic signed [5:0] cfg_data;
  logic              cfg_err;
  logic              out_valid;
  logic              out_ready;
  logic signed [6:0] out_data;
  logic              out_sat;

  fir_mac_sched dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cm[3];
  int hm[3];
  int last_data;
  int last_sat;
  int cw_addr;
  int cw_data;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic void model_reset();
    cm[0] = 8; cm[1] = 5; cm[2] = 10;
    hm[0] = 0; hm[1] = 0; hm[2] = 0;
  endfunction

  function automatic int model_out(output int sat);
    int sum;
    int r;
    sum = cm[0] * hm[0] + cm[1] * hm[1] + cm[2] * hm[2];
    sat = 0;
`ifdef FIR_MAC_SAT_EN
    r = sum;
    if (sum > 63)  begin r = 63;  sat = 1; end
    if (sum < -64) begin r = -64; sat = 1; end
`else
    r = sum % 128;
    if (r < 0)   r += 128;
    if (r >= 64) r -= 128;
`endif
    return r;
  endfunction

  task automatic do_reset();
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    model_reset();
  endtask

  task automatic cfg_write(input int a, input int d);
    cfg_we   = 1'b1;
    cfg_addr = a[1:0];
    cfg_data = d[5:0];
    tick();
    cfg_we = 1'b0;
    check("cfg_err_idle", int'(cfg_err), (a == 3) ? 1 : 0);
    if (a < 3) cm[a] = d;
    tick();
    check("cfg_err_pulse", int'(cfg_err), 0);
  endtask

  // mode 0: plain; 1: rejected write during MAC1; 2: write coinciding with acceptance
  task automatic send_sample(input int x, input int stall, input int mode);
    int  e;
    int  exp_d;
    int  exp_s;
    int  rx;
    bit  got;
    in_valid = 1'b1;
    in_data  = x[2:0];
    if (mode == 2) begin
      cfg_we   = 1'b1;
      cfg_addr = cw_addr[1:0];
      cfg_data = cw_data[5:0];
    end
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("accept_ready", int'(got), 1);
    if (!got) begin
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    if (mode == 2) begin
      cm[cw_addr] = cw_data;
      check("cfg_err_coincide", int'(cfg_err), 0);
    end
    hm[2] = hm[1];
    hm[1] = hm[0];
    hm[0] = x;
    exp_d = model_out(exp_s);
    check("in_ready_busy", int'(in_ready), 0);
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      if (mode == 1 && k == 2) begin
        cfg_we   = 1'b1;
        cfg_addr = 2'd0;
        cfg_data = 6'sd7;
      end
      tick();
      cfg_we = 1'b0;
      if (mode == 1 && k == 2) check("cfg_err_mac1", int'(cfg_err), 1);
      if (mode == 1 && k == 3) check("cfg_err_mac1_pulse", int'(cfg_err), 0);
      if (out_valid) begin
        e = k;
        break;
      end
    end
    // Counting the accepting edge as the first, out_valid shows after the fourth.
    check("latency", e, 3);
    if (e == 0) return;
    check("out_data", int'(out_data), exp_d);
    check("out_sat", int'(out_sat), exp_s);
    for (int s = 0; s < stall; s++) begin
      rx       = int'($urandom_range(0, 7)) - 4;
      in_valid = 1'b1;
      in_data  = rx[2:0];
      tick();
      check("stall_valid", int'(out_valid), 1);
      check("stall_data", int'(out_data), exp_d);
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    last_data = int'(out_data);
    last_sat  = int'(out_sat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_drop", int'(out_valid), 0);
    check("in_ready_after", int'(in_ready), 1);
  endtask

  initial begin
    int x;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    out_ready = 1'b0;
    cw_addr   = 0;
    cw_data   = 0;
    last_data = 0;
    last_sat  = 0;
    model_reset();
    tick();
    tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sat", int'(out_sat), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    sys_rst_n = 1'b1;
    check("rst_in_ready", int'(in_ready), 1);

    send_sample(1, 0, 0);
    check("seq_y0", last_data, 8);
    send_sample(2, 0, 0);
    check("seq_y1", last_data, 21);
    send_sample(3, 0, 0);
    check("seq_y2", last_data, 44);

    do_reset();
    cfg_write(0, 31);
    cfg_write(1, 31);
    cfg_write(2, 31);
    send_sample(-4, 0, 0);
    send_sample(-4, 0, 0);
    send_sample(-4, 0, 0);
`ifdef FIR_MAC_SAT_EN
    check("sat_data", last_data, -64);
    check("sat_flag", last_sat, 1);
`else
    check("wrap_data", last_data, 12);
    check("wrap_flag", last_sat, 0);
`endif

    send_sample(2, 10, 0);
    send_sample(1, 0, 1);
    cfg_write(3, 9);
    send_sample(-3, 0, 0);

    do_reset();
    cw_addr = 0;
    cw_data = 16;
    send_sample(1, 0, 2);
    check("coincide_y", last_data, 16);

    do_reset();
    in_valid = 1'b1;
    in_data  = 3'sd3;
    tick();
    in_valid = 1'b0;
    tick();
    sys_rst_n = 1'b0;
    #1;
    check("midmac_rst_valid", int'(out_valid), 0);
    check("midmac_rst_ready", int'(in_ready), 1);
    tick();
    sys_rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midmac_no_valid", int'(out_valid), 0);
    end
    send_sample(2, 0, 0);
    check("midmac_next", last_data, 16);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        cfg_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 63)) - 32);
      x = int'($urandom_range(0, 7)) - 4;
      send_sample(x, int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
